// File: rtl/sha_pkg.sv
// Shared SHA-256 constants and types used by the digest reader and its neighbours
// in the hashing pipeline.
package sha_pkg;

  // Standard SHA-256 initial chaining values
  localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
  localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
  localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
  localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
  localparam logic [31:0] SHA256_H4 = 32'h510e527f;
  localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
  localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
  localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

  localparam logic [1:0] BLK_INIT  = 2'd0;
  localparam logic [1:0] BLK_MID   = 2'd1;
  localparam logic [1:0] BLK_PAD   = 2'd2;
  localparam logic [1:0] BLK_FINAL = 2'd3;

  localparam int DIGEST_WORDS = 8;
  localparam int RECORD_WORDS = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEND
  } dr_state_e;

endpackage

// File: rtl/digest_reader_if.sv
// Result word stream toward the host side: valid/ready with an end-of-record marker.
interface digest_reader_if;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/digest_reader_lz_check.sv
// Leading-zero difficulty test: flags when the top ZERO_BITS bits of a digest are clear.
module lz_check #(
  parameter int ZERO_BITS = 32
) (
  input  logic [255:0] din,
  output logic         zero
);
  assign zero = (din[255 -: ZERO_BITS] == '0);
endmodule

// File: rtl/digest_reader.sv
// Captures the final digest, tests it against the difficulty and streams qualifying
// records (H0..H7 then nonce) to the host, while keeping hash/hit statistics.
module digest_reader
  import sha_pkg::*;
#(
  parameter int ZERO_BITS = 32,
  parameter int SEND_ALL  = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 done,
  input  logic [255:0]         h_in,
  input  logic [31:0]          nonce_in,
  input  logic                 clr_stats,
  digest_reader_if.master      stream,
  output logic                 busy,
  output logic                 hit,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     hash_count,
  output logic                 overrun
);

  localparam logic [3:0] LAST_IDX = 4'(RECORD_WORDS - 1);

  dr_state_e          state_reg;
  logic [255:0]       dig_reg;
  logic [31:0]        nonce_reg;
  logic [3:0]         idx_reg;
  logic               out_valid_reg;
  logic               out_last_reg;
  logic [31:0]        out_data_reg;
  logic               hit_reg;
  logic               overrun_reg;
  logic [CNT_W-1:0]   hash_cnt_reg;
  logic [CNT_W-1:0]   hit_cnt_reg;

  logic [31:0]        dig_words [DIGEST_WORDS];
  logic               dig_zero;
  logic [3:0]         idx_next;
  logic [31:0]        word_next;
  logic               handshake;
  logic               send_rec;

  genvar gi;
  generate
    for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_words
      assign dig_words[gi] = dig_reg[255 - 32*gi -: 32];
    end
  endgenerate

  lz_check #(.ZERO_BITS(ZERO_BITS)) u_lz (
    .din  (dig_reg),
    .zero (dig_zero)
  );

  assign idx_next  = idx_reg + 4'd1;
  assign word_next = (idx_next < 4'(DIGEST_WORDS)) ? dig_words[idx_next[2:0]] : nonce_reg;
  assign handshake = out_valid_reg & stream.out_ready;
  assign send_rec  = dig_zero | (SEND_ALL != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dig_reg       <= '0;
      nonce_reg     <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      hit_reg       <= 1'b0;
      overrun_reg   <= 1'b0;
      hash_cnt_reg  <= '0;
      hit_cnt_reg   <= '0;
    end else begin
      hit_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (done) begin
            dig_reg   <= h_in;
            nonce_reg <= nonce_in;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          hit_reg <= dig_zero;
          if (send_rec) begin
            state_reg     <= ST_SEND;
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= dig_words[0];
            out_last_reg  <= 1'b0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // Word registers only move on an accepted word, so stalls hold everything.
          if (handshake) begin
            if (idx_reg == LAST_IDX) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              idx_reg      <= idx_next;
              out_data_reg <= word_next;
              out_last_reg <= (idx_next == LAST_IDX);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (clr_stats) begin
        hash_cnt_reg <= '0;
        hit_cnt_reg  <= '0;
        overrun_reg  <= 1'b0;
      end else begin
        if (state_reg == ST_IDLE && done)
          hash_cnt_reg <= hash_cnt_reg + 1'b1;
        if (state_reg == ST_CHECK && dig_zero)
          hit_cnt_reg <= hit_cnt_reg + 1'b1;
        if (state_reg != ST_IDLE && done)
          overrun_reg <= 1'b1;
      end
    end
  end

  assign stream.out_valid = out_valid_reg;
  assign stream.out_data  = out_data_reg;
  assign stream.out_last  = out_last_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign hit        = hit_reg;
  assign hit_count  = hit_cnt_reg;
  assign hash_count = hash_cnt_reg;
  assign overrun    = overrun_reg;

endmodule
